// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - byte-wide data-memory initiator for MEM-stage loads/stores
//
// Purpose: turns one load/store command into 1, 2 or 4 big-endian single-byte
// req/ack transactions, assembles and extends load data, and holds Busy so
// the pipeline stalls until the access completes or times out.
//
// Ports:
//   Clk, Reset (sync, active-low)
//   Start, OpWe, OpSize, OpSigned, OpAd, OpWdata   command from the MEM stage
//   Busy, Done, Err, RdData                          status / load result
//   MemReq, MemWe, MemAd, MemWdata, MemRdata, MemAck byte memory port
module mem_access_master #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              OpWe,
    input  logic [1:0]        OpSize,
    input  logic              OpSigned,
    input  logic [ADDR_W-1:0] OpAd,
    input  logic [31:0]       OpWdata,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [31:0]       RdData,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAd,
    output logic [7:0]        MemWdata,
    input  logic [7:0]        MemRdata,
    input  logic              MemAck
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    // Last wait count before a stalled byte gives up: the counter would reach TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state, state_nx;
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   ad_q;
    logic [31:0]         wdata_q;   // sized store value, left-aligned so byte idx is MSB-first
    logic [1:0]          idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         acc;
    logic [31:0]         rd_data;
    logic                err;

    logic                xfer;
    logic                last_byte;
    logic                stalled_out;
    logic [1:0]          last_idx;
    logic [31:0]         acc_nx;

    function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] sz,
                                           input logic s);
        case (sz)
            2'd0:    extend = {{24{s & a[7]}}, a[7:0]};
            2'd1:    extend = {{16{s & a[15]}}, a[15:0]};
            default: extend = a;
        endcase
    endfunction

    always_comb begin
        case (size_q)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign xfer        = (state == XFER);
    assign last_byte   = (idx == last_idx);
    assign stalled_out = xfer && !MemAck && (wait_cnt == WAIT_LAST);
    assign acc_nx      = {acc[23:0], MemRdata};

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (Start) state_nx = XFER;
            XFER: if ((MemAck && last_byte) || stalled_out) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: command latch, byte sequencing, load assembly
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            ad_q     <= '0;
            wdata_q  <= '0;
            idx      <= 2'd0;
            wait_cnt <= '0;
            acc      <= '0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        we_q     <= OpWe;
                        size_q   <= OpSize;
                        signed_q <= OpSigned;
                        ad_q     <= OpAd;
                        case (OpSize)
                            2'd0:    wdata_q <= {OpWdata[7:0], 24'd0};
                            2'd1:    wdata_q <= {OpWdata[15:0], 16'd0};
                            default: wdata_q <= OpWdata;
                        endcase
                        idx      <= 2'd0;
                        wait_cnt <= '0;
                        acc      <= '0;
                        err      <= 1'b0;
                    end
                end
                XFER: begin
                    if (MemAck) begin
                        if (!we_q) begin
                            acc <= acc_nx;
                            if (last_byte) rd_data <= extend(acc_nx, size_q, signed_q);
                        end
                        wait_cnt <= '0;
                        idx      <= idx + 2'd1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (stalled_out) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        Busy     = (state != IDLE);
        Done     = (state == DONE);
        Err      = err;
        RdData   = rd_data;
        MemReq   = xfer;
        MemWe    = xfer & we_q;
        MemAd    = '0;
        MemWdata = 8'd0;
        if (xfer) begin
            MemAd = ad_q + ADDR_W'(idx);
            case (idx)
                2'd0:    MemWdata = wdata_q[31:24];
                2'd1:    MemWdata = wdata_q[23:16];
                2'd2:    MemWdata = wdata_q[15:8];
                default: MemWdata = wdata_q[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// tb/tb_mem_access_master.sv - self-checking bench for mem_access_master
module tb_mem_access_master;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Start = 1'b0;
    logic              OpWe = 1'b0;
    logic [1:0]        OpSize = 2'd0;
    logic              OpSigned = 1'b0;
    logic [ADDR_W-1:0] OpAd = '0;
    logic [31:0]       OpWdata = '0;
    logic              Busy, Done, Err, MemReq, MemWe;
    logic [31:0]       RdData;
    logic [ADDR_W-1:0] MemAd;
    logic [7:0]        MemWdata;
    logic [7:0]        MemRdata = 8'd0;
    logic              MemAck = 1'b0;

    mem_access_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OpWe(OpWe), .OpSize(OpSize),
        .OpSigned(OpSigned), .OpAd(OpAd), .OpWdata(OpWdata), .Busy(Busy), .Done(Done),
        .Err(Err), .RdData(RdData), .MemReq(MemReq), .MemWe(MemWe), .MemAd(MemAd),
        .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck)
    );

    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mem [0:65535];
    logic [31:0] exp_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One command, cycle-by-cycle from the negedge of the Start cycle.
    // A byte whose ack delay is >= TIMEOUT never gets acked and aborts the access.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [15:0] ad, input logic [31:0] wd,
                         input int d0, input int d1, input int d2, input int d3,
                         input logic junk_start);
        int          n, exp_done, exp_bytes, b, wcnt;
        int          dly [4];
        logic        to, seen_done, busy_ok, seq_ok, ack;
        logic [31:0] value;
        logic [15:0] a;
        logic [7:0]  exp_byte;

        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        dly = '{d0, d1, d2, d3};

        exp_done  = 1;
        exp_bytes = n;
        to        = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!to) begin
                if (dly[i] >= TIMEOUT) begin
                    to        = 1'b1;
                    exp_bytes = i;
                    exp_done += TIMEOUT;
                end else begin
                    exp_done += dly[i] + 1;
                end
            end
        end

        if (!we && !to) begin
            value = 32'd0;
            for (int i = 0; i < n; i++) begin
                a     = ad + 16'(i);
                value = (value << 8) | {24'd0, mem[a]};
            end
            if (n == 1)      exp_rd = (sg && value[7])  ? (value | 32'hFFFF_FF00) : value;
            else if (n == 2) exp_rd = (sg && value[15]) ? (value | 32'hFFFF_0000) : value;
            else             exp_rd = value;
        end

        Start    = 1'b1;
        OpWe     = we;
        OpSize   = sz;
        OpSigned = sg;
        OpAd     = ad;
        OpWdata  = wd;
        MemAck   = 1'($urandom_range(0, 1));
        check("busy_start_cycle", {31'd0, Busy}, 32'd0);
        @(negedge Clk);

        if (junk_start) begin
            OpAd   = ~ad;
            OpWe   = ~we;
            OpSize = 2'($urandom_range(0, 3));
        end else begin
            Start = 1'b0;
        end
        check("err_cleared_on_start", {31'd0, Err}, 32'd0);

        b = 0; wcnt = 0; seen_done = 1'b0; busy_ok = 1'b1; seq_ok = 1'b1;
        for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
            if (!Busy) busy_ok = 1'b0;
            if (Done) begin
                seen_done = 1'b1;
                check("done_cycle", cyc, exp_done);
                check("bytes_acked", b, exp_bytes);
                check("err", {31'd0, Err}, {31'd0, to});
                check("rddata", RdData, exp_rd);
                check("memreq_in_done", {31'd0, MemReq}, 32'd0);
                Start  = 1'b0;
                MemAck = 1'($urandom_range(0, 1));
            end else begin
                a        = ad + 16'(b);
                exp_byte = 8'(wd >> (8 * (n - 1 - b)));
                if (!MemReq || b >= n || MemAd !== a || MemWe !== we ||
                    (we && MemWdata !== exp_byte))
                    seq_ok = 1'b0;
                ack      = (b < n) && (wcnt == dly[b]);
                MemAck   = ack;
                MemRdata = (ack && !we) ? mem[a] : 8'($urandom);
                if (ack) begin
                    if (we) mem[a] = exp_byte;
                    b++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
                @(negedge Clk);
            end
        end
        Start = 1'b0;
        check("done_seen", {31'd0, seen_done}, 32'd1);
        check("busy_through_access", {31'd0, busy_ok}, 32'd1);
        check("byte_sequence", {31'd0, seq_ok}, 32'd1);
        @(negedge Clk);
        check("idle_after_done", {29'd0, Busy, Done, MemReq}, 32'd0);
        MemAck = 1'b0;
    endtask

    initial begin
        logic        rnd_we, rnd_sg;
        logic [1:0]  rnd_sz;
        logic [15:0] rnd_ad;
        int          d [4];
        bit          quiet;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge Clk);
        check("reset_outputs", {Busy, Done, Err, MemReq, MemWe},
              32'd0);
        check("reset_rddata", RdData, 32'd0);
        check("reset_memad_wdata", {8'd0, MemAd, MemWdata}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Word load across FF10..FF13
        mem[16'hFF10] = 8'h12; mem[16'hFF11] = 8'h34;
        mem[16'hFF12] = 8'h56; mem[16'hFF13] = 8'h78;
        do_op(1'b0, 2'd2, 1'b0, 16'hFF10, 32'd0, 0, 0, 0, 0, 1'b0);
        check("word_load_value", RdData, 32'h1234_5678);

        // Byte loads, signed and unsigned
        mem[16'h0100] = 8'h9C;
        do_op(1'b0, 2'd0, 1'b1, 16'h0100, 32'd0, 0, 0, 0, 0, 1'b0);
        check("byte_load_signed", RdData, 32'hFFFF_FF9C);
        do_op(1'b0, 2'd0, 1'b0, 16'h0100, 32'd0, 0, 0, 0, 0, 1'b0);
        check("byte_load_unsigned", RdData, 32'h0000_009C);

        // Halfword store wrapping FFFF -> 0000; RdData untouched
        do_op(1'b1, 2'd1, 1'b0, 16'hFFFF, 32'hAABB_CCDD, 0, 0, 0, 0, 1'b0);
        check("store_keeps_rddata", RdData, 32'h0000_009C);

        // Word store, each ack delayed 3 cycles
        do_op(1'b1, 2'd2, 1'b0, 16'h2000, 32'hAABB_CCDD, 3, 3, 3, 3, 1'b0);

        // No ack at all -> timeout with Err
        do_op(1'b0, 2'd2, 1'b0, 16'h3000, 32'd0, 9, 9, 9, 9, 1'b0);

        // Next Start clears Err; Start held during Busy must be ignored
        do_op(1'b0, 2'd1, 1'b1, 16'h4000, 32'd0, 1, 0, 0, 0, 1'b1);

        // Reset during byte 2 of a word load
        Start = 1'b1; OpWe = 1'b0; OpSize = 2'd2; OpSigned = 1'b0; OpAd = 16'h5000;
        @(negedge Clk);
        Start = 1'b0; MemAck = 1'b1; MemRdata = mem[16'h5000];
        @(negedge Clk);
        MemRdata = mem[16'h5001];
        Reset = 1'b0;
        @(negedge Clk);
        check("midreset_busy_req_done", {29'd0, Busy, MemReq, Done}, 32'd0);
        check("midreset_rddata", RdData, 32'd0);
        Reset  = 1'b1;
        MemAck = 1'b0;
        exp_rd = 32'd0;
        quiet  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (Done || Busy || MemReq) quiet = 1'b0;
        end
        check("midreset_no_done", {31'd0, quiet}, 32'd1);

        // Randomized commands, including occasional timeouts and wrap addresses
        for (int t = 0; t < 60; t++) begin
            rnd_we = 1'($urandom_range(0, 1));
            rnd_sz = 2'($urandom_range(0, 3));
            rnd_sg = 1'($urandom_range(0, 1));
            rnd_ad = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                 : 16'($urandom);
            for (int i = 0; i < 4; i++)
                d[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            do_op(rnd_we, rnd_sz, rnd_sg, rnd_ad, $urandom, d[0], d[1], d[2], d[3],
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
